consmax_lut_loader: RTL and testbench
=====================================

CONSMAX_LUT_LOADER -- requirements
Module: consmax_lut_loader

Interface
REQ-001 SHALL have parameter LUT_DATA, default 16, meaning FP LUT entry width (EXP_BIT+MAT_BIT+1).
REQ-002 SHALL have parameter LUT_ADDR, default 4, meaning per-LUT address width; total entries NENT = 2*2^LUT_ADDR (32).
REQ-003 SHALL have parameter DRAIN_CYC, default 3, meaning idle cycles between busy assertion and first write.
REQ-004 SHALL provide ports:
 clk  in  1  single clock, rising edge
 rstn  in  1  reset, asynchronous, active-low
 load_start  in  1  one-cycle request to begin a load
 load_abort  in  1  one-cycle request to cancel an active load
 load_saddr  in  LUT_ADDR+1  first write address (MSB selects LUT1)
 load_num  in  LUT_ADDR+2  number of entries, legal 1..NENT
 in_data  in  LUT_DATA  entry value
 in_valid  in  1  in_data valid
 in_ready  out  1  loader accepts in_data
 lut_waddr  out  LUT_ADDR+1  write address to ConSmax LUT port
 lut_wen  out  1  write enable to ConSmax LUT port
 lut_wdata  out  LUT_DATA  write data to ConSmax LUT port
 busy  out  1  high from accept of load_start to end of load; upstream SHALL hold idata_valid low while high
 load_done  out  1  one-cycle pulse on successful completion
 load_err  out  1  one-cycle pulse on rejected start or on abort
REQ-005 SHALL use one clock; reset asynchronous, active-low, ports named clk and rstn.

Function
REQ-006 SHALL implement FSM IDLE -> DRAIN -> LOAD -> DONE -> IDLE.
REQ-007 IDLE: load_start with 1<=load_num<=NENT SHALL latch saddr/num, enter DRAIN, busy=1 next cycle.
REQ-008 IDLE: load_start with load_num=0 or >NENT SHALL pulse load_err next cycle, stay IDLE, busy stays 0.
REQ-009 DRAIN SHALL last exactly DRAIN_CYC cycles, lut_wen=0, in_ready=0, then enter LOAD.
REQ-010 LOAD: in_ready SHALL be 1 and depend only on state (no combinational path from in_valid).
REQ-011 Each cycle with in_valid&&in_ready SHALL produce, next cycle, lut_wen=1, lut_waddr=current address, lut_wdata=in_data; otherwise lut_wen=0.
REQ-012 Address SHALL increment by 1 per accepted word, wrapping modulo NENT (NENT-1 -> 0).
REQ-013 On acceptance of the last word SHALL drop in_ready same edge and enter DONE; DONE cycle carries the final lut_wen.
REQ-014 Cycle after DONE: load_done=1 for one cycle, busy=0, state IDLE.
REQ-015 load_start while not IDLE SHALL be ignored for loading and pulse load_err; active load unaffected.
REQ-016 load_abort in DRAIN or LOAD SHALL return to IDLE next cycle: busy=0, in_ready=0, no further lut_wen beyond a write already registered, load_err pulse, no load_done; abort in IDLE/DONE ignored.
REQ-017 load_abort and load_start in same cycle: abort wins; start not reinterpreted.
REQ-018 lut_waddr/lut_wdata SHALL hold last value when lut_wen=0.
REQ-019 Throughput SHALL be one entry per cycle with in_valid continuously high.

Reset
REQ-020 rstn low SHALL force state IDLE, in_ready=0, lut_wen=0, lut_waddr=0, lut_wdata=0, busy=0, load_done=0, load_err=0, counters 0, asynchronously.
REQ-021 Reset mid-load SHALL discard the load; no load_done after release.

Structure
REQ-022 FSM state encoding, NENT and legal-length constants SHALL live in shared package consmax_pkg.
REQ-023 Single module, no sub-modules; all outputs registered.

Verification
REQ-024 Full load: saddr=0, num=32, in_valid held high -> busy next cycle, in_ready after 3 drain cycles, 32 consecutive lut_wen waddr 0..31 data matching, load_done 1 cycle after last write.
REQ-025 Wrap: saddr=30, num=4, data A,B,C,D -> waddr 30,31,0,1 with A..D, load_done once.
REQ-026 Bubbles: num=8, in_valid 1,0,0,1 pattern -> lut_wen only on accepted cycles, order preserved, addresses contiguous.
REQ-027 Errors: num=0 then num=33 -> load_err each, busy stays 0; start during LOAD -> load_err, original load completes.
REQ-028 Abort after 5 accepted words of num=16 -> exactly 5 writes, load_err pulse, no load_done, busy low next cycle.
REQ-029 Reset asserted after 10 writes -> all outputs 0 immediately; new load from saddr=0 then completes normally.

Source files
------------

// File: rtl/consmax_pkg.sv
`default_nettype none
// ============================================================================
// Module  : consmax_pkg
// Brief   : Shared FSM encoding and load-length constants for the ConSmax
//           LUT loader.
// Rev     : 1.0  initial release
// ============================================================================
package consmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_lut_addr_def = 4;
    localparam int c_len_min      = 1;

    // Two LUTs share one write port, so the entry space is twice one LUT.
    function automatic int nent(input int lut_addr);
        return 2 * (2 ** lut_addr);
    endfunction

    localparam int c_nent_def = nent(c_lut_addr_def);

    function automatic logic len_legal(input logic [31:0] num, input int max_len);
        return (num >= 32'(c_len_min)) && (num <= 32'(max_len));
    endfunction

endpackage : consmax_pkg
`default_nettype wire

// File: rtl/consmax_lut_loader.sv
`default_nettype none
// ============================================================================
// Module  : consmax_lut_loader
// Brief   : Streams FP entries into the ConSmax LUT write port after a short
//           drain window, with range check, abort and wrapping addresses.
// Rev     : 1.0  initial release
// ============================================================================
module consmax_lut_loader
    import consmax_pkg::*;
#(
    parameter int LUT_DATA  = 16,
    parameter int LUT_ADDR  = 4,
    parameter int DRAIN_CYC = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic [LUT_ADDR:0]     load_saddr,
    input  logic [LUT_ADDR+1:0]   load_num,
    input  logic [LUT_DATA-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LUT_ADDR:0]     lut_waddr,
    output logic                  lut_wen,
    output logic [LUT_DATA-1:0]   lut_wdata,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int c_nent = nent(LUT_ADDR);
    localparam int c_aw   = LUT_ADDR + 1;
    localparam int c_nw   = LUT_ADDR + 2;
    localparam int c_dw   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [c_dw-1:0] c_drain_last = c_dw'(DRAIN_CYC - 1);

    state_t           r_state;
    logic [c_aw-1:0]  r_addr;
    logic [c_nw-1:0]  r_remain;
    logic [c_dw-1:0]  r_drain_cnt;

    logic w_len_ok;
    logic w_start;
    logic w_accept;

    assign w_len_ok = len_legal(32'(load_num), c_nent);
    // An abort in the same cycle swallows any start request.
    assign w_start  = load_start && !load_abort;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_drain_cnt <= '0;
            in_ready    <= 1'b0;
            lut_waddr   <= '0;
            lut_wen     <= 1'b0;
            lut_wdata   <= '0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            lut_wen   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (w_len_ok) begin
                            r_addr      <= load_saddr;
                            r_remain    <= load_num;
                            r_drain_cnt <= '0;
                            busy        <= 1'b1;
                            if (DRAIN_CYC == 0) begin
                                r_state  <= ST_LOAD;
                                in_ready <= 1'b1;
                            end else begin
                                r_state  <= ST_DRAIN;
                            end
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (load_abort) begin
                        r_state     <= ST_IDLE;
                        busy        <= 1'b0;
                        in_ready    <= 1'b0;
                        r_remain    <= '0;
                        r_drain_cnt <= '0;
                        load_err    <= 1'b1;
                    end else begin
                        if (load_start) begin
                            load_err <= 1'b1;
                        end
                        if (r_drain_cnt == c_drain_last) begin
                            r_state     <= ST_LOAD;
                            in_ready    <= 1'b1;
                            r_drain_cnt <= '0;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + c_dw'(1);
                        end
                    end
                end

                ST_LOAD: begin
                    if (load_abort) begin
                        r_state  <= ST_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        r_remain <= '0;
                        load_err <= 1'b1;
                    end else begin
                        if (load_start) begin
                            load_err <= 1'b1;
                        end
                        if (w_accept) begin
                            lut_wen   <= 1'b1;
                            lut_waddr <= r_addr;
                            lut_wdata <= in_data;
                            // Address width equals log2(NENT), so it wraps naturally.
                            r_addr    <= r_addr + c_aw'(1);
                            r_remain  <= r_remain - c_nw'(1);
                            if (r_remain == c_nw'(1)) begin
                                in_ready <= 1'b0;
                                r_state  <= ST_DONE;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    if (load_start) begin
                        load_err <= 1'b1;
                    end
                    r_state   <= ST_IDLE;
                    busy      <= 1'b0;
                    load_done <= 1'b1;
                    r_remain  <= '0;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule : consmax_lut_loader
`default_nettype wire

// File: tb/tb_consmax_lut_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_consmax_lut_loader
// Brief   : Directed/randomized bench for consmax_lut_loader with a
//           write-list reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_consmax_lut_loader;

    localparam int LD = 16;
    localparam int LA = 4;
    localparam int DC = 3;
    localparam int NE = 32;

    logic            clk;
    logic            rstn;
    logic            load_start;
    logic            load_abort;
    logic [LA:0]     load_saddr;
    logic [LA+1:0]   load_num;
    logic [LD-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [LA:0]     lut_waddr;
    logic            lut_wen;
    logic [LD-1:0]   lut_wdata;
    logic            busy;
    logic            load_done;
    logic            load_err;

    consmax_lut_loader #(
        .LUT_DATA  (LD),
        .LUT_ADDR  (LA),
        .DRAIN_CYC (DC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_start (load_start),
        .load_abort (load_abort),
        .load_saddr (load_saddr),
        .load_num   (load_num),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lut_waddr  (lut_waddr),
        .lut_wen    (lut_wen),
        .lut_wdata  (lut_wdata),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int err_cnt     = 0;

    typedef struct {
        int addr;
        int data;
        int c;
    } wr_t;

    wr_t wq[$];
    int  done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observed LUT traffic, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (lut_wen)   wq.push_back('{int'(lut_waddr), int'(lut_wdata), cyc});
            if (load_done) done_q.push_back(cyc);
            if (load_err)  err_cnt <= err_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string tag, input int saddr, input int num, input int mode,
                           input int abort_after, input int extra_start_at);
        int  data[$];
        int  idx, k, guard, t0, err0, done0, n_exp, n_chk, v, rdy;
        bit  aborted, ready_seen, extra_done;
        for (int i = 0; i < num; i++) data.push_back(int'($urandom_range(0, 65535)));
        wq.delete();
        err0 = err_cnt; done0 = done_q.size();
        aborted = 0; ready_seen = 0; extra_done = 0;
        idx = 0; k = 0; guard = 0;
        load_saddr = 5'(saddr); load_num = 6'(num); load_start = 1'b1;
        in_valid = (mode == 0); in_data = 16'(data[0]);
        @(posedge clk); #1;
        load_start = 1'b0; t0 = cyc;
        check({tag, " busy after start"}, 64'(busy), 64'd1);
        check({tag, " in_ready in drain"}, 64'(in_ready), 64'd0);
        while (idx < num && guard < 500) begin
            guard++;
            rdy = int'(in_ready);
            if (rdy != 0 && !ready_seen) begin
                ready_seen = 1;
                check({tag, " drain length"}, 64'(cyc - t0), 64'(DC));
            end
            if (abort_after >= 0 && idx == abort_after && rdy != 0) begin
                load_abort = 1'b1; in_valid = 1'b0;
                @(posedge clk); #1;
                load_abort = 1'b0; aborted = 1;
                check({tag, " busy after abort"}, 64'(busy), 64'd0);
                check({tag, " in_ready after abort"}, 64'(in_ready), 64'd0);
                break;
            end
            if (mode == 0)      v = 1;
            else if (mode == 1) v = ((k % 4) == 0 || (k % 4) == 3) ? 1 : 0;
            else                v = int'($urandom_range(0, 1));
            if (extra_start_at >= 0 && idx == extra_start_at && rdy != 0 && !extra_done) begin
                load_start = 1'b1; load_saddr = 5'(saddr + 7); load_num = 6'd3; extra_done = 1;
            end
            in_valid = v[0]; in_data = 16'(data[idx]);
            @(posedge clk);
            if (v != 0 && rdy != 0) idx++;
            if (rdy != 0) k++;
            #1;
            load_start = 1'b0;
        end
        in_valid = 1'b0; load_start = 1'b0;
        if (!aborted) check({tag, " words accepted"}, 64'(idx), 64'(num));
        guard = 0;
        while (busy && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, " busy clears"}, 64'(busy), 64'd0);
        @(negedge clk); #1;
        n_exp = aborted ? abort_after : num;
        check({tag, " write count"}, 64'(wq.size()), 64'(n_exp));
        n_chk = (wq.size() < n_exp) ? wq.size() : n_exp;
        for (int i = 0; i < n_chk; i++) begin
            check({tag, " waddr"}, 64'(wq[i].addr), 64'((saddr + i) % NE));
            check({tag, " wdata"}, 64'(wq[i].data), 64'(data[i]));
            if (mode == 0 && !aborted)
                check({tag, " back-to-back"}, 64'(wq[i].c - wq[0].c), 64'(i));
        end
        if (mode == 0 && !aborted && wq.size() > 0)
            check({tag, " first write cycle"}, 64'(wq[0].c - t0), 64'(DC + 1));
        check({tag, " done pulses"}, 64'(done_q.size() - done0), aborted ? 64'd0 : 64'd1);
        if (!aborted && done_q.size() > done0 && wq.size() > 0)
            check({tag, " done after last write"}, 64'(done_q[$] - wq[$].c), 64'd1);
        check({tag, " err pulses"}, 64'(err_cnt - err0), 64'(int'(aborted) + int'(extra_done)));
        if (!aborted && wq.size() > 0) begin
            check({tag, " waddr hold"}, 64'(lut_waddr), 64'(wq[$].addr));
            check({tag, " wdata hold"}, 64'(lut_wdata), 64'(wq[$].data));
            check({tag, " wen idle"}, 64'(lut_wen), 64'd0);
        end
    endtask

    task automatic bad_start(input string tag, input int num);
        int err0;
        err0 = err_cnt;
        load_num = 6'(num); load_saddr = 5'd0; load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        check({tag, " err pulse"}, 64'(load_err), 64'd1);
        check({tag, " busy stays low"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, " err one cycle"}, 64'(load_err), 64'd0);
        check({tag, " busy still low"}, 64'(busy), 64'd0);
        check({tag, " in_ready low"}, 64'(in_ready), 64'd0);
        check({tag, " err count"}, 64'(err_cnt - err0), 64'd1);
    endtask

    initial begin
        int guard, done0;
        rstn = 1'b1; load_start = 1'b0; load_abort = 1'b0;
        load_saddr = '0; load_num = '0; in_data = '0; in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("reset in_ready",  64'(in_ready),  64'd0);
        check("reset lut_wen",   64'(lut_wen),   64'd0);
        check("reset lut_waddr", 64'(lut_waddr), 64'd0);
        check("reset lut_wdata", 64'(lut_wdata), 64'd0);
        check("reset busy",      64'(busy),      64'd0);
        check("reset load_done", 64'(load_done), 64'd0);
        check("reset load_err",  64'(load_err),  64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        do_load("full",   0, 32, 0, -1, -1);
        do_load("wrap",  30,  4, 0, -1, -1);
        do_load("bubble", int'($urandom_range(0, NE - 1)), 8, 1, -1, -1);
        bad_start("num0",  0);
        bad_start("num33", 33);
        do_load("start_in_load", int'($urandom_range(0, NE - 1)), 12, 0, -1, 4);
        do_load("abort", 3, 16, 0, 5, -1);
        for (int r = 0; r < 4; r++)
            do_load("random", int'($urandom_range(0, NE - 1)), int'($urandom_range(1, NE)), 2, -1, -1);

        wq.delete();
        load_saddr = 5'd0; load_num = 6'd16; load_start = 1'b1;
        in_valid = 1'b1; in_data = 16'(int'($urandom_range(0, 65535)));
        @(posedge clk); #1;
        load_start = 1'b0;
        guard = 0;
        while (wq.size() < 10 && guard < 100) begin
            @(negedge clk); guard++;
        end
        check("reset_mid writes before reset", 64'(wq.size() >= 10), 64'd1);
        #1 rstn = 1'b0;
        #1;
        check("reset_mid in_ready",  64'(in_ready),  64'd0);
        check("reset_mid lut_wen",   64'(lut_wen),   64'd0);
        check("reset_mid lut_waddr", 64'(lut_waddr), 64'd0);
        check("reset_mid lut_wdata", 64'(lut_wdata), 64'd0);
        check("reset_mid busy",      64'(busy),      64'd0);
        check("reset_mid load_done", 64'(load_done), 64'd0);
        check("reset_mid load_err",  64'(load_err),  64'd0);
        in_valid = 1'b0;
        done0 = done_q.size();
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("reset_mid no done after release", 64'(done_q.size() - done0), 64'd0);
        check("reset_mid busy after release", 64'(busy), 64'd0);
        do_load("post_reset", 0, 32, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_consmax_lut_loader
`default_nettype wire
